// File: rtl/int_seq_pkg.sv
// Shared types and default vector addresses for the interrupt sequencer.
// Imported by the sequencer top and its testbench-visible parameters.
package int_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RES_HOLD,
    RES_PEND,
    RES_SEQ,
    HW_SEQ,
    SW_SEQ
  } state_t;

  typedef enum logic [1:0] {
    SEL_RES,
    SEL_NMI,
    SEL_IRQ
  } vec_sel_t;

  localparam int unsigned RES_MIN_LOW_DEF = 2;
  localparam logic [15:0] VEC_NMI_DEF = 16'hFFFA;
  localparam logic [15:0] VEC_RES_DEF = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ_DEF = 16'hFFFE;

endpackage

// File: rtl/interrupt_sequencer_nmi_edge_detector.sv
// Falling-edge capture of the NMI pin; pending flag held until the
// NMI vector is taken.
module nmi_edge_detector (
  input  logic clk_1,
  input  logic clear,
  input  logic nmi_n,
  input  logic take,
  output logic nmi_pend
);

  logic nmi_prev;

  // A fresh edge in the take cycle wins over the clear.
  always_ff @(posedge clk_1 or posedge clear) begin
    if (clear) begin
      nmi_prev <= 1'b1;
      nmi_pend <= 1'b0;
    end else begin
      nmi_prev <= nmi_n;
      nmi_pend <= (nmi_prev & ~nmi_n)
                | (nmi_pend & ~take);
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// Sequences reset, NMI, IRQ and BRK entry: arbitration, BRK forcing,
// write suppression during reset and vector selection with NMI hijack.
module interrupt_sequencer
  import int_seq_pkg::*;
#(
  parameter int unsigned RES_MIN_LOW = RES_MIN_LOW_DEF,
  parameter logic [15:0] VEC_NMI = VEC_NMI_DEF,
  parameter logic [15:0] VEC_RES = VEC_RES_DEF,
  parameter logic [15:0] VEC_IRQ = VEC_IRQ_DEF
) (
  input  logic        clk_1,
  input  logic        reset,
  input  logic        rdy,
  input  logic        sync,
  input  logic        brk_op,
  input  logic        vec_fetch,
  input  logic        seq_done,
  input  logic        res_n,
  input  logic        nmi_n,
  input  logic        irq_n,
  input  logic        i_flag,
  output logic        force_brk,
  output logic        write_inhibit,
  output logic        b_flag,
  output logic [15:0] vector_addr,
  output logic        nmi_ack,
  output logic        busy
);

  localparam int CW = $clog2(RES_MIN_LOW + 1);
  localparam logic [CW-1:0] RES_MAX = CW'(RES_MIN_LOW);

  state_t         state_q;
  state_t         state_d;
  state_t         eff;
  vec_sel_t       live_sel;
  logic [CW-1:0]  res_cnt;
  logic [15:0]    live_vec;
  logic [15:0]    vec_lat;
  logic           vec_lat_valid;
  logic           res_hit;
  logic           in_seq;
  logic           in_res;
  logic           int_req_q;
  logic           irq_pend;
  logic           nmi_pend;
  logic           latch;
  logic           take;

  nmi_edge_detector u_nmi (
    .clk_1    (clk_1),
    .clear    (reset),
    .nmi_n    (nmi_n),
    .take     (take),
    .nmi_pend (nmi_pend)
  );

  assign res_hit  = (res_cnt == RES_MAX);
  assign irq_pend = ~irq_n & ~i_flag;
  assign in_seq   = state_q inside {RES_SEQ, HW_SEQ, SW_SEQ};
  assign in_res   = state_q inside {RES_HOLD, RES_PEND, RES_SEQ};
  assign latch    = rdy & vec_fetch & in_seq;
  assign take     = latch & (live_sel == SEL_NMI);

  always_comb begin
    live_sel = SEL_IRQ;
    if (in_res)
      live_sel = SEL_RES;
    else if (nmi_pend)
      live_sel = SEL_NMI;
  end

  always_comb begin
    live_vec = VEC_IRQ;
    unique case (live_sel)
      SEL_RES: live_vec = VEC_RES;
      SEL_NMI: live_vec = VEC_NMI;
      default: live_vec = VEC_IRQ;
    endcase
  end

  // seq_done retires the old sequence before the sync decision.
  always_comb begin
    state_d   = state_q;
    force_brk = 1'b0;
    eff       = state_q;
    if (rdy && seq_done && in_seq)
      eff = IDLE;
    if (rdy) begin
      state_d = eff;
      if (sync) begin
        priority case (1'b1)
          eff == RES_PEND: begin
            state_d   = RES_SEQ;
            force_brk = 1'b1;
          end
          eff == IDLE && int_req_q: begin
            state_d   = HW_SEQ;
            force_brk = 1'b1;
          end
          eff == IDLE && brk_op:
            state_d = SW_SEQ;
          default: ;
        endcase
      end
    end
    if (state_q == RES_HOLD)
      state_d = res_n ? RES_PEND : RES_HOLD;
    else if (res_hit)
      state_d = RES_HOLD;
  end

  always_ff @(posedge clk_1 or posedge reset) begin
    if (reset) begin
      state_q       <= RES_PEND;
      res_cnt       <= '0;
      int_req_q     <= 1'b0;
      vec_lat       <= VEC_RES;
      vec_lat_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      if (res_n)
        res_cnt <= '0;
      else if (!res_hit)
        res_cnt <= res_cnt + 1'b1;
      if (rdy)
        int_req_q <= nmi_pend | irq_pend;
      if (latch)
        vec_lat <= live_vec;
      if (res_hit)
        vec_lat_valid <= 1'b0;
      else if (rdy && seq_done && in_seq)
        vec_lat_valid <= 1'b0;
      else if (latch)
        vec_lat_valid <= 1'b1;
    end
  end

  assign vector_addr   = vec_lat_valid ? vec_lat : live_vec;
  assign nmi_ack       = take;
  assign write_inhibit = in_res;
  assign b_flag        = (state_q == SW_SEQ);
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer with a cycle-level reference
// model compared on every falling clock edge.
module tb_interrupt_sequencer;

  logic        clk_1;
  logic        reset;
  logic        rdy;
  logic        sync;
  logic        brk_op;
  logic        vec_fetch;
  logic        seq_done;
  logic        res_n;
  logic        nmi_n;
  logic        irq_n;
  logic        i_flag;
  logic        force_brk;
  logic        write_inhibit;
  logic        b_flag;
  logic [15:0] vector_addr;
  logic        nmi_ack;
  logic        busy;

  int errs;
  int checks;

  interrupt_sequencer dut (
    .clk_1         (clk_1),
    .reset         (reset),
    .rdy           (rdy),
    .sync          (sync),
    .brk_op        (brk_op),
    .vec_fetch     (vec_fetch),
    .seq_done      (seq_done),
    .res_n         (res_n),
    .nmi_n         (nmi_n),
    .irq_n         (irq_n),
    .i_flag        (i_flag),
    .force_brk     (force_brk),
    .write_inhibit (write_inhibit),
    .b_flag        (b_flag),
    .vector_addr   (vector_addr),
    .nmi_ack       (nmi_ack),
    .busy          (busy)
  );

  initial clk_1 = 1'b0;
  always #5 clk_1 = ~clk_1;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: seq 0=none 1=reset 2=hardware 3=software.
  int          low_run;
  bit          holding;
  bit          res_wait;
  int          seq;
  bit          prev_n;
  bit          owed;
  bit          poll;
  bit          have_vec;
  logic [15:0] vec;

  function automatic logic [15:0] live_vec();
    if (holding || res_wait || seq == 1) return 16'hFFFC;
    if (owed) return 16'hFFFA;
    return 16'hFFFE;
  endfunction

  always @(posedge clk_1 or posedge reset) begin : model
    bit hit, latch, take, fall, o_owed;
    if (reset) begin
      low_run = 0; holding = 0; res_wait = 1; seq = 0;
      prev_n = 1; owed = 0; poll = 0; have_vec = 0; vec = 16'h0;
    end else begin
      hit    = low_run >= 2;
      latch  = rdy && vec_fetch && seq != 0;
      take   = latch && live_vec() == 16'hFFFA;
      fall   = prev_n && !nmi_n;
      o_owed = owed;
      if (latch) vec = live_vec();
      if (holding) begin
        if (res_n) begin holding = 0; res_wait = 1; end
      end else if (hit) begin
        holding = 1; res_wait = 0; seq = 0; have_vec = 0;
      end else if (rdy) begin
        if (latch) have_vec = 1;
        if (seq_done && seq != 0) begin seq = 0; have_vec = 0; end
        if (sync) begin
          if (res_wait) begin res_wait = 0; seq = 1; end
          else if (seq == 0 && poll) seq = 2;
          else if (seq == 0 && brk_op) seq = 3;
        end
      end
      if (rdy) poll = o_owed | (!irq_n && !i_flag);
      owed    = fall ? 1'b1 : (take ? 1'b0 : owed);
      prev_n  = nmi_n;
      low_run = res_n ? 0 : low_run + 1;
    end
  end

  always @(negedge clk_1) begin : cmp
    bit rs, idle_after, efb, eack;
    rs = holding || res_wait || seq == 1;
    idle_after = !holding && !res_wait &&
                 (seq == 0 || (rdy && seq_done));
    efb  = sync && rdy && (res_wait || (idle_after && poll));
    eack = rdy && vec_fetch && seq != 0 && live_vec() == 16'hFFFA;
    chk("m_force_brk", 16'(force_brk), 16'(efb));
    chk("m_write_inhibit", 16'(write_inhibit), 16'(rs));
    chk("m_b_flag", 16'(b_flag), 16'(seq == 3));
    chk("m_vector", vector_addr, have_vec ? vec : live_vec());
    chk("m_nmi_ack", 16'(nmi_ack), 16'(eack));
    chk("m_busy", 16'(busy), 16'(rs || holding || seq != 0));
  end

  task automatic go(input logic s, input logic b,
                    input logic vf, input logic sd);
    sync = s; brk_op = b; vec_fetch = vf; seq_done = sd;
    @(negedge clk_1);
  endtask

  task automatic nxt();
    @(posedge clk_1);
    #1;
    sync = 0; brk_op = 0; vec_fetch = 0; seq_done = 0;
  endtask

  initial begin
    errs = 0; checks = 0;
    reset = 1; rdy = 1; sync = 0; brk_op = 0; vec_fetch = 0;
    seq_done = 0; res_n = 1; nmi_n = 1; irq_n = 1; i_flag = 0;

    go(0, 0, 0, 0);
    chk("rst_busy", 16'(busy), 16'd1);
    chk("rst_wi", 16'(write_inhibit), 16'd1);
    chk("rst_vec", vector_addr, 16'hFFFC);
    chk("rst_force", 16'(force_brk), 16'd0);
    nxt();
    reset = 0;
    nxt(); nxt();

    // reset entry sequence
    go(1, 0, 0, 0); chk("res_force", 16'(force_brk), 16'd1); nxt();
    go(0, 0, 1, 0); chk("res_vec", vector_addr, 16'hFFFC);
    chk("res_b", 16'(b_flag), 16'd0);
    chk("res_wi", 16'(write_inhibit), 16'd1); nxt();
    go(0, 0, 0, 1); nxt();
    go(0, 0, 0, 0); chk("res_done_busy", 16'(busy), 16'd0);
    chk("res_done_wi", 16'(write_inhibit), 16'd0); nxt();

    // one-cycle res_n glitch is filtered
    res_n = 0; nxt(); res_n = 1; nxt(); nxt();
    go(0, 0, 0, 0); chk("glitch_busy", 16'(busy), 16'd0); nxt();

    // IRQ entry
    irq_n = 0; nxt();
    go(1, 0, 0, 0); chk("irq_force", 16'(force_brk), 16'd1); nxt();
    irq_n = 1;
    go(0, 0, 1, 0); chk("irq_vec", vector_addr, 16'hFFFE); nxt();
    go(0, 0, 0, 1); nxt();

    // masked IRQ
    irq_n = 0; i_flag = 1; nxt();
    go(1, 0, 0, 0); chk("mask_force", 16'(force_brk), 16'd0); nxt();
    go(0, 0, 0, 0); chk("mask_busy", 16'(busy), 16'd0); nxt();
    irq_n = 1; i_flag = 0; nxt();

    // reset asserted in the middle of an IRQ sequence
    irq_n = 0; nxt();
    go(1, 0, 0, 0); nxt();
    irq_n = 1; res_n = 0; nxt(); nxt(); nxt();
    go(0, 0, 0, 0); chk("hold_busy", 16'(busy), 16'd1);
    chk("hold_wi", 16'(write_inhibit), 16'd1); nxt();
    res_n = 1; nxt();
    go(1, 0, 0, 0); chk("rehold_force", 16'(force_brk), 16'd1); nxt();
    go(0, 0, 1, 0); chk("rehold_vec", vector_addr, 16'hFFFC); nxt();
    go(0, 0, 0, 1); nxt();

    // NMI hijacks a BRK sequence
    go(1, 1, 0, 0); chk("brk_force", 16'(force_brk), 16'd0); nxt();
    nmi_n = 0; nxt();
    go(0, 0, 1, 0); chk("hij_vec", vector_addr, 16'hFFFA);
    chk("hij_b", 16'(b_flag), 16'd1);
    chk("hij_ack", 16'(nmi_ack), 16'd1); nxt();
    go(0, 0, 0, 0); chk("hij_ack_off", 16'(nmi_ack), 16'd0);
    chk("hij_vec_hold", vector_addr, 16'hFFFA); nxt();
    go(0, 0, 0, 1); nxt();
    go(1, 0, 0, 0); chk("hij_cleared", 16'(force_brk), 16'd0); nxt();
    nmi_n = 1; nxt();

    // long NMI low gives exactly one sequence
    begin
      int pulses;
      pulses = 0;
      nmi_n = 0; nxt(); nxt();
      go(1, 0, 0, 0); chk("nmi1_force", 16'(force_brk), 16'd1); nxt();
      go(0, 0, 1, 0); chk("nmi1_vec", vector_addr, 16'hFFFA);
      chk("nmi1_ack", 16'(nmi_ack), 16'd1); nxt();
      go(0, 0, 0, 1); nxt();
      for (int i = 0; i < 15; i++) begin
        go(i % 3 == 0, 0, 0, 0);
        if (force_brk) pulses++;
        nxt();
      end
      chk("nmi_level_once", 16'(pulses), 16'd0);
      nmi_n = 1; nxt();
      nmi_n = 0; nxt(); nxt();
      go(1, 0, 0, 0); chk("nmi2_force", 16'(force_brk), 16'd1); nxt();
      go(0, 0, 1, 0); chk("nmi2_ack", 16'(nmi_ack), 16'd1); nxt();
      go(0, 0, 0, 1); nxt();
      nmi_n = 1; nxt();
    end

    // rdy stall across sync; NMI edge during the stall
    irq_n = 0; nxt();
    irq_n = 1; rdy = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) nmi_n = 0;
      go(1, 0, 0, 0); chk("stall_force", 16'(force_brk), 16'd0);
      nxt();
    end
    rdy = 1;
    go(1, 0, 0, 0); chk("stall_go", 16'(force_brk), 16'd1); nxt();
    go(0, 0, 1, 0); chk("stall_vec", vector_addr, 16'hFFFA);
    chk("stall_ack", 16'(nmi_ack), 16'd1); nxt();
    go(0, 0, 0, 1); nxt();
    nmi_n = 1; nxt();

    // seq_done with sync, then vec_fetch with seq_done
    irq_n = 0; nxt();
    go(1, 0, 0, 0); nxt();
    go(0, 0, 1, 0); nxt();
    go(1, 0, 0, 1); chk("done_sync_force", 16'(force_brk), 16'd1); nxt();
    irq_n = 1;
    go(0, 0, 1, 1); chk("vf_done_vec", vector_addr, 16'hFFFE);
    chk("vf_done_busy", 16'(busy), 16'd1); nxt();
    go(0, 0, 0, 0); chk("vf_done_idle", 16'(busy), 16'd0); nxt();
    nxt();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
